jk_reg_array: RTL and testbench

Parametrised WIDTH-bit bank of JK flip-flops with a selectable clock edge and four operating modes. Modes are per-bit JK, synchronous up-counter, synchronous down-counter and serial shift, all built from the JK toggle law. It is the multi-bit successor to the single-bit JK flip-flop. It serves as the general-purpose state, counter and shift element in the FlipFlops library.

---
 rtl/jk_array_pkg.sv | 11 +
 rtl/jk_reg_array_cell.sv | 50 +++++
 rtl/jk_reg_array.sv | 105 ++++++++++
 tb/tb_jk_reg_array.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_array_pkg.sv
// Shared mode encoding for the jk_reg_array bank of JK flip-flops.
package jk_array_pkg;

    typedef logic [1:0] jk_mode_t;

    localparam jk_mode_t MODE_JK  = 2'b00;
    localparam jk_mode_t MODE_UP  = 2'b01;
    localparam jk_mode_t MODE_DN  = 2'b10;
    localparam jk_mode_t MODE_SHL = 2'b11;

endpackage

// File: rtl/jk_reg_array_cell.sv
// Single JK flip-flop with async reset value, synchronous load and cell enable.
// The active clock edge is chosen at elaboration by NEG_EDGE.
module jk_cell #(
    parameter logic NEG_EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ce,
    input  logic ld,
    input  logic d,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        if (ld) begin
            w_next = d;
        end else if (ce) begin
            case ({j, k})
                2'b01:   w_next = 1'b0;
                2'b10:   w_next = 1'b1;
                2'b11:   w_next = ~r_q;
                default: w_next = r_q;
            endcase
        end
    end

    generate
        if (NEG_EDGE) begin : g_neg
            always_ff @(negedge clk or posedge rst) begin
                if (rst) r_q <= rst_val;
                else     r_q <= w_next;
            end
        end else begin : g_pos
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_q <= rst_val;
                else     r_q <= w_next;
            end
        end
    endgenerate

    assign q = r_q;

endmodule

// File: rtl/jk_reg_array.sv
// WIDTH-bit JK flip-flop bank: per-bit JK, up/down counter and shift-left modes.
// Define JK_ARRAY_SAT_EN to make the counter modes saturate instead of wrapping.
module jk_reg_array
    import jk_array_pkg::*;
#(
    parameter int unsigned          WIDTH    = 8,
    parameter logic [WIDTH-1:0]     RST_VAL  = '0,
    parameter logic                 NEG_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc
);

    jk_mode_t         w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_up_chain;
    logic [WIDTH-1:0] w_dn_chain;
    logic             w_tc;

    assign w_mode = jk_mode_t'(mode);

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
    always_comb begin
        logic acc_up;
        logic acc_dn;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        w_up_chain = '0;
        w_dn_chain = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_chain[i] = acc_up;
            w_dn_chain[i] = acc_dn;
            acc_up = acc_up & w_q[i];
            acc_dn = acc_dn & ~w_q[i];
        end
    end

    assign w_tc = ((w_mode == MODE_UP) && (&w_q)) ||
                  ((w_mode == MODE_DN) && ~(|w_q));

    always_comb begin
        w_j = j;
        w_k = k;
        case (w_mode)
            MODE_UP: begin
                w_j = w_up_chain;
                w_k = w_up_chain;
            end
            MODE_DN: begin
                w_j = w_dn_chain;
                w_k = w_dn_chain;
            end
            MODE_SHL: begin
                w_j = {w_q[WIDTH-2:0], sin};
                w_k = ~{w_q[WIDTH-2:0], sin};
            end
            default: begin
                w_j = j;
                w_k = k;
            end
        endcase
`ifdef JK_ARRAY_SAT_EN
        // tc is only ever high in a counting mode, so this freezes the counter at its end.
        if (w_tc) begin
            w_j = '0;
            w_k = '0;
        end
`endif
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            jk_cell #(
                .NEG_EDGE(NEG_EDGE)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .rst_val (RST_VAL[i]),
                .ce      (en),
                .ld      (load),
                .d       (d[i]),
                .j       (w_j[i]),
                .k       (w_k[i]),
                .q       (w_q[i])
            );
        end
    endgenerate

    assign q  = w_q;
    assign qn = ~w_q;
    assign tc = w_tc;

endmodule

// File: tb/tb_jk_reg_array.sv
// Bench for jk_reg_array: directed steps, randomized steps against a behavioural
// model, async reset checks, and a posedge instance checked on both clock edges.
module tb_jk_reg_array;
    import jk_array_pkg::*;

    localparam logic [7:0] RV = 8'hA5;

    // clock/reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = MODE_JK;
    logic [7:0] j = '0;
    logic [7:0] k = '0;
    logic       sin = 1'b0;
    logic       load = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] q;
    logic [7:0] qn;
    logic       tc;

    logic       p_rst = 1'b1;
    logic       p_load = 1'b0;
    logic [7:0] p_q;
    logic [7:0] p_qn;
    logic       p_tc;

    jk_reg_array #(.WIDTH(8), .RST_VAL(RV), .NEG_EDGE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .sin(sin),
        .load(load), .d(d), .q(q), .qn(qn), .tc(tc)
    );

    jk_reg_array #(.WIDTH(8), .RST_VAL(8'h00), .NEG_EDGE(1'b0)) u_dut_pe (
        .clk(clk), .rst(p_rst), .en(1'b1), .mode(MODE_UP), .j(8'h00), .k(8'h00),
        .sin(1'b0), .load(p_load), .d(8'h00), .q(p_q), .qn(p_qn), .tc(p_tc)
    );

    // scoreboard
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_q;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Behavioural reference: the register's arithmetic meaning of each mode.
    function automatic logic [7:0] model_next(input logic ld, input logic [7:0] dd,
                                              input logic e, input logic [1:0] md,
                                              input logic [7:0] jj, input logic [7:0] kk,
                                              input logic s, input logic [7:0] cur);
        logic [7:0] r;
        r = cur;
        if (ld) return dd;
        if (!e) return cur;
        case (md)
            MODE_JK: begin
                for (int i = 0; i < 8; i++) begin
                    if (jj[i] && kk[i]) r[i] = ~cur[i];
                    else if (jj[i])     r[i] = 1'b1;
                    else if (kk[i])     r[i] = 1'b0;
                end
            end
            MODE_UP: begin
`ifdef JK_ARRAY_SAT_EN
                if (cur == 8'hFF) return cur;
`endif
                r = cur + 8'd1;
            end
            MODE_DN: begin
`ifdef JK_ARRAY_SAT_EN
                if (cur == 8'h00) return cur;
`endif
                r = cur - 8'd1;
            end
            default: r = {cur[6:0], s};
        endcase
        return r;
    endfunction

    function automatic logic model_tc(input logic [1:0] md, input logic [7:0] cur);
        return (md == MODE_UP && cur == 8'hFF) || (md == MODE_DN && cur == 8'h00);
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".q"}, q, m_q);
        check({tag, ".qn"}, qn, ~m_q);
        check({tag, ".tc"}, {7'b0, tc}, {7'b0, model_tc(mode, m_q)});
    endtask

    // driver: set inputs between falling edges, check tc, clock once, check state
    task automatic step(input string tag, input logic ld, input logic [7:0] dd,
                        input logic e, input logic [1:0] md, input logic [7:0] jj,
                        input logic [7:0] kk, input logic s);
        load = ld; d = dd; en = e; mode = md; j = jj; k = kk; sin = s;
        #1;
        check({tag, ".tc_pre"}, {7'b0, tc}, {7'b0, model_tc(md, m_q)});
        exp_q.push_back(model_next(ld, dd, e, md, jj, kk, s, m_q));
        @(negedge clk);
        #1;
        m_q = exp_q.pop_front();
        check_state(tag);
    endtask

    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        #1;
        m_q = RV;
        check_state({tag, ".async"});
        @(negedge clk);
        #1;
        check_state({tag, ".held"});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        int p_cnt;

        // Reset asserted between edges must show RST_VAL at once.
        #2;
        rst = 1'b1;
        #1;
        m_q = RV;
        check("rst.q", q, 8'hA5);
        check("rst.qn", qn, 8'h5A);
        check("rst_pe.q", p_q, 8'h00);
        @(negedge clk);
        #1;
        check_state("rst.edge");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // JK mode
        step("jk.load0f", 1'b1, 8'h0F, 1'b0, MODE_JK, 8'h00, 8'h00, 1'b0);
        step("jk.setclr", 1'b0, 8'h00, 1'b1, MODE_JK, 8'hF0, 8'h0F, 1'b0);
        check("jk.const1", q, 8'hF0);
        step("jk.toggle", 1'b0, 8'h00, 1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0);
        check("jk.const2", q, 8'h0F);
        step("jk.hold", 1'b0, 8'h00, 1'b1, MODE_JK, 8'h00, 8'h00, 1'b0);
        check("jk.const3", q, 8'h0F);

        // Up counter across the wrap/saturation point
        step("up.loadfd", 1'b1, 8'hFD, 1'b1, MODE_UP, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++)
            step("up.count", 1'b0, 8'h00, 1'b1, MODE_UP, 8'h00, 8'h00, 1'b0);

        // Down counter, enable-low hold, load beating enable-low
        step("dn.load01", 1'b1, 8'h01, 1'b1, MODE_DN, 8'h00, 8'h00, 1'b0);
        step("dn.to00", 1'b0, 8'h00, 1'b1, MODE_DN, 8'h00, 8'h00, 1'b0);
        check("dn.const00", q, 8'h00);
        step("dn.wrap", 1'b0, 8'h00, 1'b1, MODE_DN, 8'h00, 8'h00, 1'b0);
        step("dn.en0", 1'b0, 8'h00, 1'b0, MODE_DN, 8'h00, 8'h00, 1'b0);
        step("dn.load3c", 1'b1, 8'h3C, 1'b0, MODE_DN, 8'h00, 8'h00, 1'b0);
        check("dn.const3c", q, 8'h3C);

        // Shift left
        step("shl.load81", 1'b1, 8'h81, 1'b1, MODE_SHL, 8'h00, 8'h00, 1'b0);
        step("shl.s1", 1'b0, 8'h00, 1'b1, MODE_SHL, 8'h00, 8'h00, 1'b1);
        check("shl.const03", q, 8'h03);
        step("shl.s0", 1'b0, 8'h00, 1'b1, MODE_SHL, 8'h00, 8'h00, 1'b0);
        check("shl.const06", q, 8'h06);
        step("shl.s1b", 1'b0, 8'h00, 1'b1, MODE_SHL, 8'h00, 8'h00, 1'b1);
        check("shl.const0d", q, 8'h0D);

        // Reset in the middle of a count
        step("mid.up", 1'b0, 8'h00, 1'b1, MODE_UP, 8'h00, 8'h00, 1'b0);
        rst_pulse("mid.rst");

        // Randomized steps, biased toward counter boundary load values
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0:       rd = 8'h00;
                1:       rd = 8'hFF;
                2:       rd = 8'hFE;
                3:       rd = 8'h01;
                default: rd = 8'($urandom);
            endcase
            if ((n % 37) == 36) rst_pulse("rnd.rst");
            step("rnd", ($urandom_range(0, 7) == 0), rd, ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Posedge instance: counts only on rising edges
        rst = 1'b0;
        p_rst = 1'b0;
        p_cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            p_cnt++;
            check("pe.rise.q", p_q, 8'(p_cnt));
            check("pe.rise.qn", p_qn, ~8'(p_cnt));
            @(negedge clk);
            #1;
            check("pe.fall.q", p_q, 8'(p_cnt));
            check("pe.fall.tc", {7'b0, p_tc}, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
